// File: rtl/jtag_master_if.sv
// Command/status bundle between a host and jtag_master.
interface jtag_master_if;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  len;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    modport master (output start, output op, output len, output din,
                    input busy, input done, input dout);
    modport slave  (input start, input op, input len, input din,
                    output busy, output done, output dout);
endinterface

// File: rtl/jtag_master.sv
// JTAG master: runs TAP reset, IR scan and DR scan sequences with a clk-derived TCK
// and captures TDO bits into dout.
module jtag_master #(
    parameter int DIV     = 2,
    parameter int TDO_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    jtag_master_if.slave cmd,
    output logic         TCK,
    output logic         TMS,
    output logic         TDI,
    input  logic         TDO
);
    typedef enum logic [2:0] {IDLE, RST_SEQ, HDR, SHIFT, POST, FIN} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [5:0] LAT      = 6'(TDO_LAT);

    state_t      state_r, state_nx_s;
    logic [7:0]  div_cnt_r;
    logic [4:0]  bit_cnt_r, bit_nx_s, len_r;
    logic [5:0]  edge_cnt_r, cap_off_s;
    logic [31:0] din_r, dout_r;
    logic        tck_r, tms_r, tdi_r, busy_r, done_r, is_ir_r;
    logic        accept_s, active_s, rise_s, period_end_s, load_s, ir_s;
    logic        tms_nx_s, tdi_nx_s, cap_en_s;

    // TMS level for period idx of a stepping state.
    function automatic logic tms_for(state_t st, logic [4:0] idx, logic ir, logic [4:0] n_m1);
        logic v;
        case (st)
            RST_SEQ: v = (idx < 5'd5);
            HDR:     v = ir ? (idx < 5'd2) : (idx == 5'd0);
            SHIFT:   v = (idx == n_m1);
            POST:    v = (idx == 5'd0);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] last_idx(state_t st, logic ir, logic [4:0] n_m1);
        logic [4:0] v;
        case (st)
            RST_SEQ: v = 5'd5;
            HDR:     v = ir ? 5'd3 : 5'd2;
            SHIFT:   v = n_m1;
            POST:    v = 5'd1;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    function automatic state_t next_seq(state_t st);
        state_t v;
        case (st)
            HDR:     v = SHIFT;
            SHIFT:   v = POST;
            default: v = FIN;
        endcase
        return v;
    endfunction

    assign active_s     = (state_r == RST_SEQ) || (state_r == HDR) ||
                          (state_r == SHIFT) || (state_r == POST);
    assign rise_s       = active_s && !tck_r && (div_cnt_r == DIV_LAST);
    assign period_end_s = active_s && tck_r && (div_cnt_r == DIV_LAST);
    assign load_s       = accept_s || period_end_s;
    assign tms_nx_s     = tms_for(state_nx_s, bit_nx_s, ir_s, len_r);
    assign tdi_nx_s     = (state_nx_s == SHIFT) ? din_r[bit_nx_s] : 1'b0;

    // Edge index relative to the first SHIFT rise, shifted back by the target latency.
    assign cap_off_s = edge_cnt_r - LAT;
    assign cap_en_s  = rise_s && ((state_r == SHIFT) || (state_r == POST)) &&
                       (edge_cnt_r >= LAT) && (cap_off_s <= {1'b0, len_r});

    // Next-state and period-index decode.
    always_comb begin
        state_nx_s = state_r;
        bit_nx_s   = bit_cnt_r;
        ir_s       = is_ir_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                ir_s = (cmd.op == 2'd1);
                if (cmd.start && (cmd.op != 2'd3)) begin
                    accept_s   = 1'b1;
                    state_nx_s = (cmd.op == 2'd0) ? RST_SEQ : HDR;
                    bit_nx_s   = 5'd0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RST_SEQ, HDR, SHIFT, POST: begin
                if (period_end_s && (bit_cnt_r == last_idx(state_r, is_ir_r, len_r))) begin
                    state_nx_s = next_seq(state_r);
                    bit_nx_s   = 5'd0;
                end else if (period_end_s) begin
                    bit_nx_s = bit_cnt_r + 5'd1;
                end else begin
                    bit_nx_s = bit_cnt_r;
                end
            end
            FIN:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State and period index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 5'd0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_nx_s;
        end
    end

    // TCK phase generator: DIV clks low, then DIV clks high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_r     <= 1'b0;
            div_cnt_r <= 8'd0;
        end else if (!active_s) begin
            tck_r     <= 1'b0;
            div_cnt_r <= 8'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            tck_r     <= ~tck_r;
            div_cnt_r <= 8'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

    // TMS/TDI update only at the start of a low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tms_r <= 1'b1;
            tdi_r <= 1'b0;
        end else if (load_s) begin
            tms_r <= tms_nx_s;
            tdi_r <= tdi_nx_s;
        end
    end

    // Command latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r   <= 5'd0;
            din_r   <= 32'd0;
            is_ir_r <= 1'b0;
        end else if (accept_s) begin
            len_r   <= cmd.len;
            din_r   <= cmd.din;
            is_ir_r <= (cmd.op == 2'd1);
        end
    end

    // TDO capture; a RESET command leaves dout untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r     <= 32'd0;
            edge_cnt_r <= 6'd0;
        end else begin
            if (accept_s && (cmd.op != 2'd0)) begin
                dout_r <= 32'd0;
            end else if (cap_en_s) begin
                dout_r[cap_off_s[4:0]] <= TDO;
            end
            if ((state_r == HDR) && (state_nx_s == SHIFT)) begin
                edge_cnt_r <= 6'd0;
            end else if (rise_s && ((state_r == SHIFT) || (state_r == POST))) begin
                edge_cnt_r <= edge_cnt_r + 6'd1;
            end
        end
    end

    // Status outputs follow the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == RST_SEQ) || (state_nx_s == HDR) ||
                      (state_nx_s == SHIFT) || (state_nx_s == POST);
            done_r <= (state_nx_s == FIN);
        end
    end

    assign TCK       = tck_r;
    assign TMS       = tms_r;
    assign TDI       = tdi_r;
    assign cmd.busy  = busy_r;
    assign cmd.done  = done_r;
    assign cmd.dout  = dout_r;
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: loopback instance (DIV=1, TDO_LAT=0) and TAP-target instance (DIV=2, TDO_LAT=1).
module tb_jtag_master;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtag_master_if ifa();
    jtag_master_if ifb();
    logic tck_a, tms_a, tdi_a, tck_b, tms_b, tdi_b, tdo_b;

    jtag_master #(.DIV(1), .TDO_LAT(0)) dut_a (.clk(clk), .rst_n(rst_n), .cmd(ifa),
        .TCK(tck_a), .TMS(tms_a), .TDI(tdi_a), .TDO(tdi_a));
    jtag_master #(.DIV(2), .TDO_LAT(1)) dut_b (.clk(clk), .rst_n(rst_n), .cmd(ifb),
        .TCK(tck_b), .TMS(tms_b), .TDI(tdi_b), .TDO(tdo_b));

    // Target TAP holding IDCODE in its DR, with one extra TCK of TDO latency.
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR} tap_t;
    tap_t        tap_st = RTI;
    logic [31:0] tap_dr = 32'd0;
    logic        tdo_q = 1'b0, tdo_d = 1'b0;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDDR : PAUDR;
            PAUDR: return m ? EX2DR : PAUDR;
            EX2DR: return m ? UPDDR : SHDR;
            UPDDR: return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPDIR : PAUIR;
            PAUIR: return m ? EX2IR : PAUIR;
            EX2IR: return m ? UPDIR : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck_b) begin
        if (tap_st == CAPDR) tap_dr <= 32'h1234_5678;
        else if (tap_st == SHDR) tap_dr <= {tdi_b, tap_dr[31:1]};
        tap_st <= tap_next(tap_st, tms_b);
    end
    always @(negedge tck_b) begin
        tdo_q <= (tap_st == SHDR) ? tap_dr[0] : 1'b0;
        tdo_d <= tdo_q;
    end
    assign tdo_b = tdo_d;

    // Monitors: log TMS/TDI and clk stamp at every TCK rise, count done pulses.
    int   cyc = 0;
    logic tck_a_p = 1'b0, tck_b_p = 1'b0;
    logic tms_qa[$], tdi_qa[$], tms_qb[$], tdi_qb[$];
    int   cyc_qa[$], cyc_qb[$];
    int   done_na = 0, done_nb = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tck_a && !tck_a_p) begin
            tms_qa.push_back(tms_a); tdi_qa.push_back(tdi_a); cyc_qa.push_back(cyc);
        end
        if (tck_b && !tck_b_p) begin
            tms_qb.push_back(tms_b); tdi_qb.push_back(tdi_b); cyc_qb.push_back(cyc);
        end
        if (ifa.done) done_na <= done_na + 1;
        if (ifb.done) done_nb <= done_nb + 1;
        tck_a_p <= tck_a;
        tck_b_p <= tck_b;
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected per-period TMS/TDI (bit i = period i) and period count for a command.
    function automatic void build_exp(input logic [1:0] op, input logic [4:0] len, input logic [31:0] din,
                                      output logic [63:0] tms, output logic [63:0] tdi, output int n);
        int p;
        tms = 64'd0; tdi = 64'd0; n = 0;
        if (op == 2'd0) begin
            tms[5:0] = 6'b011111;
            n = 6;
        end else begin
            if (op == 2'd1) begin tms[1:0] = 2'b11; p = 4; end
            else begin tms[0] = 1'b1; p = 3; end
            for (int k = 0; k <= int'(len); k++) tdi[p + k] = din[k];
            tms[p + int'(len)] = 1'b1;
            p = p + int'(len) + 1;
            tms[p] = 1'b1;
            n = p + 2;
        end
    endfunction

    task automatic issue(input bit sel, input logic [1:0] op, input logic [4:0] len, input logic [31:0] din);
        @(posedge clk); #1;
        if (sel) begin ifb.start = 1'b1; ifb.op = op; ifb.len = len; ifb.din = din; end
        else     begin ifa.start = 1'b1; ifa.op = op; ifa.len = len; ifa.din = din; end
        @(posedge clk); #1;
        if (sel) ifb.start = 1'b0;
        else     ifa.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int busy_n, output bit seen, output bit busy_at_done);
        busy_n = 0; seen = 1'b0; busy_at_done = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (sel ? ifb.done : ifa.done) begin
                seen = 1'b1;
                busy_at_done = sel ? ifb.busy : ifa.busy;
            end else if (sel ? ifb.busy : ifa.busy) begin
                busy_n++;
            end
        end
    endtask

    task automatic run_cmd(input bit sel, input string tag, input logic [1:0] op, input logic [4:0] len,
                           input logic [31:0] din, input logic [31:0] exp_dout, input int div);
        logic [63:0] e_tms, e_tdi, a_tms, a_tdi;
        int e_n, base, base_done, busy_n, n, per_bad, dc;
        bit seen, bad;
        build_exp(op, len, din, e_tms, e_tdi, e_n);
        base      = sel ? tms_qb.size() : tms_qa.size();
        base_done = sel ? done_nb : done_na;
        issue(sel, op, len, din);
        wait_done(sel, busy_n, seen, bad);
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " busy low at done"}, 64'(bad), 64'd0);
        check({tag, " busy cycles"}, 64'(busy_n), 64'(e_n * 2 * div));
        repeat (3) @(negedge clk);
        n = (sel ? tms_qb.size() : tms_qa.size()) - base;
        check({tag, " tck periods"}, 64'(n), 64'(e_n));
        a_tms = 64'd0; a_tdi = 64'd0; per_bad = 0;
        for (int i = 0; i < n && i < 64; i++) begin
            a_tms[i] = sel ? tms_qb[base + i] : tms_qa[base + i];
            a_tdi[i] = sel ? tdi_qb[base + i] : tdi_qa[base + i];
            if (i > 0) begin
                if (sel ? (cyc_qb[base + i] - cyc_qb[base + i - 1] != 2 * div)
                        : (cyc_qa[base + i] - cyc_qa[base + i - 1] != 2 * div)) per_bad++;
            end
        end
        check({tag, " tms seq"}, a_tms, e_tms);
        check({tag, " tdi seq"}, a_tdi, e_tdi);
        check({tag, " tck period"}, 64'(per_bad), 64'd0);
        dc = (sel ? done_nb : done_na) - base_done;
        check({tag, " done pulses"}, 64'(dc), 64'd1);
        check({tag, " dout"}, 64'(sel ? ifb.dout : ifa.dout), 64'(exp_dout));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  len;
        logic [31:0] din;
        logic [31:0] exp_dout;
    } vec_t;
    vec_t vt[6];

    initial begin
        int base, bd, busy_n, busy_hi;
        bit seen, bad;
        vt[0] = '{2'd1, 5'd3,  32'h0000_0007, 32'h0000_0007};
        vt[1] = '{2'd2, 5'd31, 32'hA5C3_0F1E, 32'hA5C3_0F1E};
        vt[2] = '{2'd2, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001};
        vt[3] = '{2'd0, 5'd7,  32'h0000_0055, 32'h0000_0001};
        vt[4] = '{2'd2, 5'd7,  32'hFFFF_FF5A, 32'h0000_005A};
        vt[5] = '{2'd1, 5'd15, 32'h1234_BEEF, 32'h0000_BEEF};

        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.op = 2'd0; ifa.len = 5'd0; ifa.din = 32'd0;
        ifb.start = 1'b0; ifb.op = 2'd0; ifb.len = 5'd0; ifb.din = 32'd0;
        repeat (3) @(negedge clk);
        check("rst tck", 64'({tck_a, tck_b}), 64'd0);
        check("rst tms", 64'({tms_a, tms_b}), 64'd3);
        check("rst tdi", 64'({tdi_a, tdi_b}), 64'd0);
        check("rst busy/done", 64'({ifa.busy, ifa.done, ifb.busy, ifb.done}), 64'd0);
        check("rst dout", 64'(ifa.dout | ifb.dout), 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++)
            run_cmd(1'b0, $sformatf("vec%0d", v), vt[v].op, vt[v].len, vt[v].din, vt[v].exp_dout, 1);

        run_cmd(1'b1, "tap reset", 2'd0, 5'd0, 32'd0, 32'd0, 2);
        run_cmd(1'b1, "tap idcode", 2'd2, 5'd31, 32'd0, 32'h1234_5678, 2);
        check("tap ends rti", 64'(tap_st), 64'(RTI));

        // Start while busy must not disturb the running scan.
        base = tms_qa.size(); bd = done_na;
        issue(1'b0, 2'd2, 5'd31, 32'hA5C3_0F1E);
        repeat (20) @(negedge clk);
        ifa.start = 1'b1; ifa.op = 2'd2; ifa.len = 5'd3; ifa.din = 32'h0000_FFFF;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_done(1'b0, busy_n, seen, bad);
        repeat (5) @(negedge clk);
        check("busy-start dout", 64'(ifa.dout), 64'hA5C3_0F1E);
        check("busy-start done pulses", 64'(done_na - bd), 64'd1);
        check("busy-start periods", 64'(tms_qa.size() - base), 64'd37);

        // Reserved op in IDLE is a no-op.
        base = tms_qa.size(); bd = done_na; busy_hi = 0;
        issue(1'b0, 2'd3, 5'd5, 32'h0000_00FF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.busy) busy_hi++;
        end
        check("op3 busy", 64'(busy_hi), 64'd0);
        check("op3 tck", 64'(tms_qa.size() - base), 64'd0);
        check("op3 done", 64'(done_na - bd), 64'd0);
        check("op3 dout", 64'(ifa.dout), 64'hA5C3_0F1E);

        // Start coinciding with done is dropped.
        issue(1'b0, 2'd0, 5'd0, 32'd0);
        wait_done(1'b0, busy_n, seen, bad);
        check("fin-start done seen", 64'(seen), 64'd1);
        ifa.start = 1'b1; ifa.op = 2'd1; ifa.len = 5'd3; ifa.din = 32'h0000_000F;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        base = tms_qa.size(); busy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.busy) busy_hi++;
        end
        check("fin-start busy", 64'(busy_hi), 64'd0);
        check("fin-start tck", 64'(tms_qa.size() - base), 64'd0);
        check("fin-start dout", 64'(ifa.dout), 64'hA5C3_0F1E);

        // Reset in the middle of SHIFT aborts without done.
        bd = done_na;
        issue(1'b0, 2'd2, 5'd31, 32'hFFFF_FFFF);
        repeat (16) @(negedge clk);
        check("pre-abort busy", 64'(ifa.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort tck", 64'(tck_a), 64'd0);
        check("abort tms", 64'(tms_a), 64'd1);
        check("abort tdi", 64'(tdi_a), 64'd0);
        check("abort busy/done", 64'({ifa.busy, ifa.done}), 64'd0);
        check("abort dout", 64'(ifa.dout), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort no done", 64'(done_na - bd), 64'd0);
        run_cmd(1'b0, "post-abort reset", 2'd0, 5'd0, 32'd0, 32'd0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
